// File: rtl/data_mem_controller.sv
// data_mem_controller
//   Arbitrates the data-memory request/ready handshakes of NUM_CONSUMERS cores
//   onto NUM_CHANNELS memory channels. Each channel runs its own FSM:
//   claim a pending consumer (round-robin), forward the request to memory,
//   wait for memory, then relay the result until the consumer drops its valid.
//
// Ports
//   clk                     rising-edge clock
//   reset                   asynchronous, active-low reset
//   consumer_read_*         per-core read request (valid/address) and response (ready/data)
//   consumer_write_*        per-core write request (valid/address/data) and response (ready)
//   mem_read_*              per-channel read request (valid/address) and response (ready/data)
//   mem_write_*             per-channel write request (valid/address/data) and response (ready)
module data_mem_controller #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 2
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_CONSUMERS-1:0]                  consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                  consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                  consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                  consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                   mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]    mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                   mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]    mem_read_data,
    output logic [NUM_CHANNELS-1:0]                   mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]    mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]    mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                   mem_write_ready
);

    localparam int IW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        READ_WAITING,
        WRITE_WAITING,
        READ_RELAYING,
        WRITE_RELAYING
    } state_t;

    state_t                  state            [NUM_CHANNELS];
    state_t                  state_d          [NUM_CHANNELS];
    logic [IW-1:0]           current_consumer [NUM_CHANNELS];
    logic [IW-1:0]           current_d        [NUM_CHANNELS];
    logic [IW-1:0]           rr_ptr           [NUM_CHANNELS];
    logic [IW-1:0]           rr_d             [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0] claimed, claimed_d;

    logic [NUM_CONSUMERS-1:0]                consumer_read_ready_d;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data_d;
    logic [NUM_CONSUMERS-1:0]                consumer_write_ready_d;
    logic [NUM_CHANNELS-1:0]                 mem_read_valid_d;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address_d;
    logic [NUM_CHANNELS-1:0]                 mem_write_valid_d;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address_d;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data_d;

    // Consumers granted by lower-indexed channels in the current cycle.
    logic [NUM_CONSUMERS-1:0] granted;
    logic                     scan_found;
    logic [IW-1:0]            scan_sel;
    logic [IW-1:0]            scan_cand;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        claimed_d              = claimed;
        consumer_read_ready_d  = consumer_read_ready;
        consumer_read_data_d   = consumer_read_data;
        consumer_write_ready_d = consumer_write_ready;
        mem_read_valid_d       = mem_read_valid;
        mem_read_address_d     = mem_read_address;
        mem_write_valid_d      = mem_write_valid;
        mem_write_address_d    = mem_write_address;
        mem_write_data_d       = mem_write_data;
        granted                = '0;
        scan_found             = 1'b0;
        scan_sel               = '0;
        scan_cand              = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_d[c]   = state[c];
            current_d[c] = current_consumer[c];
            rr_d[c]      = rr_ptr[c];
        end

        // Channels are evaluated in ascending order; each sees the grants
        // already made this cycle, so a consumer is never double-granted.
        // Eligibility uses the registered claimed vector, so a consumer being
        // released this cycle cannot be re-granted until the next edge.
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            unique case (state[c])
                IDLE: begin
                    scan_found = 1'b0;
                    scan_sel   = '0;
                    for (int k = 0; k < NUM_CONSUMERS; k++) begin
                        scan_cand = IW'((int'(rr_ptr[c]) + k) % NUM_CONSUMERS);
                        if (!scan_found && !claimed[scan_cand] && !granted[scan_cand] &&
                            (consumer_read_valid[scan_cand] || consumer_write_valid[scan_cand])) begin
                            scan_found = 1'b1;
                            scan_sel   = scan_cand;
                        end
                    end
                    if (scan_found) begin
                        granted[scan_sel]   = 1'b1;
                        claimed_d[scan_sel] = 1'b1;
                        current_d[c]        = scan_sel;
                        rr_d[c]             = IW'((int'(scan_sel) + 1) % NUM_CONSUMERS);
                        // Read wins over write for the same consumer.
                        if (consumer_read_valid[scan_sel]) begin
                            mem_read_valid_d[c]   = 1'b1;
                            mem_read_address_d[c] = consumer_read_address[scan_sel];
                            state_d[c]            = READ_WAITING;
                        end else begin
                            mem_write_valid_d[c]   = 1'b1;
                            mem_write_address_d[c] = consumer_write_address[scan_sel];
                            mem_write_data_d[c]    = consumer_write_data[scan_sel];
                            state_d[c]             = WRITE_WAITING;
                        end
                    end
                end
                READ_WAITING: begin
                    if (mem_read_ready[c]) begin
                        mem_read_valid_d[c]                           = 1'b0;
                        consumer_read_data_d[current_consumer[c]]     = mem_read_data[c];
                        consumer_read_ready_d[current_consumer[c]]    = 1'b1;
                        state_d[c]                                    = READ_RELAYING;
                    end
                end
                WRITE_WAITING: begin
                    if (mem_write_ready[c]) begin
                        mem_write_valid_d[c]                          = 1'b0;
                        consumer_write_ready_d[current_consumer[c]]   = 1'b1;
                        state_d[c]                                    = WRITE_RELAYING;
                    end
                end
                READ_RELAYING: begin
                    if (!consumer_read_valid[current_consumer[c]]) begin
                        consumer_read_ready_d[current_consumer[c]] = 1'b0;
                        claimed_d[current_consumer[c]]             = 1'b0;
                        state_d[c]                                 = IDLE;
                    end
                end
                WRITE_RELAYING: begin
                    if (!consumer_write_valid[current_consumer[c]]) begin
                        consumer_write_ready_d[current_consumer[c]] = 1'b0;
                        claimed_d[current_consumer[c]]              = 1'b0;
                        state_d[c]                                  = IDLE;
                    end
                end
                default: state_d[c] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            claimed              <= '0;
            consumer_read_ready  <= '0;
            consumer_read_data   <= '0;
            consumer_write_ready <= '0;
            mem_read_valid       <= '0;
            mem_read_address     <= '0;
            mem_write_valid      <= '0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state[c]            <= IDLE;
                current_consumer[c] <= '0;
                rr_ptr[c]           <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples the pre-edge values regardless of statement order.
            claimed              <= claimed_d;
            consumer_read_ready  <= consumer_read_ready_d;
            consumer_read_data   <= consumer_read_data_d;
            consumer_write_ready <= consumer_write_ready_d;
            mem_read_valid       <= mem_read_valid_d;
            mem_read_address     <= mem_read_address_d;
            mem_write_valid      <= mem_write_valid_d;
            mem_write_address    <= mem_write_address_d;
            mem_write_data       <= mem_write_data_d;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state[c]            <= state_d[c];
                current_consumer[c] <= current_d[c];
                rr_ptr[c]           <= rr_d[c];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_controller.sv
// tb_data_mem_controller
//   Directed bench for data_mem_controller. A 2-channel instance runs a
//   cycle-by-cycle vector table (single read, single write, read-over-write)
//   followed by hand-written reset, contention and mid-transaction reset
//   sequences; a 1-channel instance checks round-robin fairness.
module tb_data_mem_controller;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 2-channel instance
    logic [3:0]       rv, wv, crr, cwr;
    logic [3:0][7:0]  raddr, waddr, wdata, crd;
    logic [1:0]       mrv, mrr, mwv, mwr;
    logic [1:0][7:0]  mra, mrd, mwa, mwd;

    // 1-channel instance
    logic [3:0]       f_rv, f_wv, f_crr, f_cwr;
    logic [3:0][7:0]  f_raddr, f_waddr, f_wdata, f_crd;
    logic [0:0]       f_mrv, f_mrr, f_mwv, f_mwr;
    logic [0:0][7:0]  f_mra, f_mrd, f_mwa, f_mwd;

    data_mem_controller #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(rv), .consumer_read_address(raddr),
        .consumer_read_ready(crr), .consumer_read_data(crd),
        .consumer_write_valid(wv), .consumer_write_address(waddr),
        .consumer_write_data(wdata), .consumer_write_ready(cwr),
        .mem_read_valid(mrv), .mem_read_address(mra),
        .mem_read_ready(mrr), .mem_read_data(mrd),
        .mem_write_valid(mwv), .mem_write_address(mwa),
        .mem_write_data(mwd), .mem_write_ready(mwr)
    );

    data_mem_controller #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) dut_fair (
        .clk(clk), .reset(reset),
        .consumer_read_valid(f_rv), .consumer_read_address(f_raddr),
        .consumer_read_ready(f_crr), .consumer_read_data(f_crd),
        .consumer_write_valid(f_wv), .consumer_write_address(f_waddr),
        .consumer_write_data(f_wdata), .consumer_write_ready(f_cwr),
        .mem_read_valid(f_mrv), .mem_read_address(f_mra),
        .mem_read_ready(f_mrr), .mem_read_data(f_mrd),
        .mem_write_valid(f_mwv), .mem_write_address(f_mwa),
        .mem_write_data(f_mwd), .mem_write_ready(f_mwr)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [3:0]  rv;
        logic [3:0]  wv;
        logic [1:0]  mrr;
        logic [1:0]  mwr;
        logic [1:0]  e_mrv;
        logic [1:0]  e_mwv;
        logic [3:0]  e_crr;
        logic [3:0]  e_cwr;
        logic [7:0]  e_mra0;
        logic [7:0]  e_mwa0;
        logic [7:0]  e_mwd0;
        logic [31:0] e_crd;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    initial begin
        // Single read core0 @0x12 -> 0xA5, single write core2 0x3C @0x40,
        // then core1 read 0x10 and write 0x20 together (read first).
        vecs[0]  = '{4'b0001, 4'b0000, 2'b00, 2'b00, 2'b01, 2'b00, 4'b0000, 4'b0000, 8'h12, 8'h00, 8'h00, 32'h0000_0000};
        vecs[1]  = '{4'b0001, 4'b0000, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0001, 4'b0000, 8'h12, 8'h00, 8'h00, 32'h0000_00A5};
        vecs[2]  = '{4'b0001, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0001, 4'b0000, 8'h12, 8'h00, 8'h00, 32'h0000_00A5};
        vecs[3]  = '{4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 4'b0000, 8'h12, 8'h00, 8'h00, 32'h0000_00A5};
        vecs[4]  = '{4'b0000, 4'b0100, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0000, 4'b0000, 8'h12, 8'h40, 8'h3C, 32'h0000_00A5};
        vecs[5]  = '{4'b0000, 4'b0100, 2'b00, 2'b01, 2'b00, 2'b00, 4'b0000, 4'b0100, 8'h12, 8'h40, 8'h3C, 32'h0000_00A5};
        vecs[6]  = '{4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 4'b0000, 8'h12, 8'h40, 8'h3C, 32'h0000_00A5};
        vecs[7]  = '{4'b0010, 4'b0010, 2'b00, 2'b00, 2'b01, 2'b00, 4'b0000, 4'b0000, 8'h10, 8'h40, 8'h3C, 32'h0000_00A5};
        vecs[8]  = '{4'b0010, 4'b0010, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0010, 4'b0000, 8'h10, 8'h40, 8'h3C, 32'h0000_A5A5};
        vecs[9]  = '{4'b0000, 4'b0010, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 4'b0000, 8'h10, 8'h40, 8'h3C, 32'h0000_A5A5};
        vecs[10] = '{4'b0000, 4'b0010, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0000, 4'b0000, 8'h10, 8'h20, 8'h77, 32'h0000_A5A5};
        vecs[11] = '{4'b0000, 4'b0010, 2'b00, 2'b01, 2'b00, 2'b00, 4'b0000, 4'b0010, 8'h10, 8'h20, 8'h77, 32'h0000_A5A5};
        vecs[12] = '{4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 4'b0000, 8'h10, 8'h20, 8'h77, 32'h0000_A5A5};

        reset = 1'b0;
        rv = '0; wv = '0; mrr = '0; mwr = '0;
        raddr = '0; waddr = '0; wdata = '0;
        raddr[0] = 8'h12; raddr[1] = 8'h10;
        waddr[1] = 8'h20; wdata[1] = 8'h77;
        waddr[2] = 8'h40; wdata[2] = 8'h3C;
        mrd[0] = 8'hA5; mrd[1] = 8'h5A;
        f_rv = '0; f_wv = '0; f_mrr = '0; f_mwr = '0;
        f_raddr = '0; f_waddr = '0; f_wdata = '0; f_mrd = '0;
        f_raddr[0] = 8'h30; f_raddr[1] = 8'h31; f_mrd[0] = 8'hC3;

        step();
        check("reset_mrv", 64'(mrv), 64'(2'b00));
        check("reset_crr", 64'(crr), 64'(4'b0000));
        check("reset_mra", 64'(mra), 64'(16'h0000));
        reset = 1'b1;

        // Table-driven part
        for (int i = 0; i < NVEC; i++) begin
            rv  = vecs[i].rv;
            wv  = vecs[i].wv;
            mrr = vecs[i].mrr;
            mwr = vecs[i].mwr;
            step();
            check($sformatf("v%0d_mrv", i),  64'(mrv),        64'(vecs[i].e_mrv));
            check($sformatf("v%0d_mwv", i),  64'(mwv),        64'(vecs[i].e_mwv));
            check($sformatf("v%0d_crr", i),  64'(crr),        64'(vecs[i].e_crr));
            check($sformatf("v%0d_cwr", i),  64'(cwr),        64'(vecs[i].e_cwr));
            check($sformatf("v%0d_mra0", i), 64'(mra[0]),     64'(vecs[i].e_mra0));
            check($sformatf("v%0d_mwa0", i), 64'(mwa[0]),     64'(vecs[i].e_mwa0));
            check($sformatf("v%0d_mwd0", i), 64'(mwd[0]),     64'(vecs[i].e_mwd0));
            check($sformatf("v%0d_crd", i),  64'(crd),        64'(vecs[i].e_crd));
        end
        rv = '0; wv = '0; mrr = '0; mwr = '0;

        // Reset between edges clears every output at once, including read data.
        #2;
        reset = 1'b0;
        #1;
        check("areset_crd", 64'(crd), 64'h0);
        check("areset_mwa", 64'(mwa), 64'h0);
        check("areset_mwd", 64'(mwd), 64'h0);
        check("areset_mra", 64'(mra), 64'h0);
        #2;
        reset = 1'b1;

        // Contention: all four cores read at once on two channels.
        raddr = {8'h03, 8'h02, 8'h01, 8'h00};
        rv = 4'b1111;
        step();
        check("cont_grant1_mrv", 64'(mrv), 64'(2'b11));
        check("cont_grant1_mra", 64'(mra), 64'(16'h0100));
        mrr = 2'b11;
        step();
        check("cont_resp1_crr", 64'(crr), 64'(4'b0011));
        check("cont_resp1_mrv", 64'(mrv), 64'(2'b00));
        check("cont_resp1_crd", 64'(crd), 64'(32'h0000_5AA5));
        mrr = 2'b00;
        rv  = 4'b1100;
        step();
        check("cont_rel1_crr", 64'(crr), 64'(4'b0000));
        check("cont_rel1_mrv", 64'(mrv), 64'(2'b00));
        step();
        check("cont_grant2_mrv", 64'(mrv), 64'(2'b11));
        check("cont_grant2_mra", 64'(mra), 64'(16'h0302));
        mrr = 2'b11;
        step();
        check("cont_resp2_crr", 64'(crr), 64'(4'b1100));
        check("cont_resp2_crd", 64'(crd), 64'(32'h5AA5_5AA5));
        mrr = 2'b00;
        rv  = 4'b0000;
        step();
        check("cont_rel2_crr", 64'(crr), 64'(4'b0000));

        // Fairness on one channel: cores 0 and 1 re-request right after release.
        f_rv = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("fair%0d_mrv", i), 64'(f_mrv), 64'(1'b1));
            check($sformatf("fair%0d_addr", i), 64'(f_mra[0]), 64'(8'h30 + 8'(i % 2)));
            f_mrr = 1'b1;
            step();
            check($sformatf("fair%0d_crr", i), 64'(f_crr), 64'(4'b0001 << (i % 2)));
            f_mrr = 1'b0;
            f_rv[i % 2] = 1'b0;
            step();
            check($sformatf("fair%0d_rel", i), 64'(f_crr), 64'(4'b0000));
            f_rv[i % 2] = 1'b1;
        end
        f_rv = '0;

        // Mid-transaction reset while READ_WAITING, then a fresh grant.
        raddr[0] = 8'h12;
        rv = 4'b0001;
        step();
        check("mid_wait_mrv", 64'(mrv), 64'(2'b01));
        check("mid_wait_mra", 64'(mra[0]), 64'(8'h12));
        #2;
        reset = 1'b0;
        #1;
        check("mid_reset_mrv", 64'(mrv), 64'(2'b00));
        check("mid_reset_mra", 64'(mra), 64'h0);
        check("mid_reset_crd", 64'(crd), 64'h0);
        rv = 4'b1000;
        raddr[3] = 8'h33;
        #2;
        reset = 1'b1;
        step();
        check("post_reset_mrv", 64'(mrv), 64'(2'b01));
        check("post_reset_mra", 64'(mra[0]), 64'(8'h33));
        check("post_reset_crr", 64'(crr), 64'(4'b0000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
